// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, direct-mapped one-word-line I-cache, static JAL / BHT branch prediction.
// Optional macro BHT_EN adds the 2-bit branch history table; without it branches predict not taken.
module inst_fetch #(
    parameter int ICACHE_LINES = 64,
    parameter int BHT_ENTRIES  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_IF,
    input  logic        jp_wrong,
    input  logic [31:0] jp_target,
    input  logic        bp_upd,
    input  logic [31:0] bp_upd_pc,
    input  logic        bp_upd_taken,
    output logic        ins_flag,
    output logic [31:0] ins,
    output logic        jp_flag,
    output logic [31:0] jp_pc,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int BHT_W = $clog2(BHT_ENTRIES);

    typedef enum logic [1:0] {RUN, WAIT, ABORT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        ins_flag_reg, ins_flag_next;
    logic [31:0] ins_reg, ins_next;
    logic        jp_flag_reg, jp_flag_next;
    logic [31:0] jp_pc_reg, jp_pc_next;
    logic        mc_req_reg, mc_req_next;
    logic [31:0] mc_addr_reg, mc_addr_next;

    // Cache storage: valid bits are flops (cleared on reset), tag/data are plain RAM arrays.
    logic [ICACHE_LINES-1:0] valid_reg;
    logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
    logic [31:0]             data_mem [ICACHE_LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] fill_idx;
    logic             fill_en;
    logic             hit;
    logic [31:0]      hit_word;

    assign rd_idx   = pc_reg[IDX_W+1:2];
    assign fill_idx = mc_addr_reg[IDX_W+1:2];
    assign hit_word = data_mem[rd_idx];
    assign hit      = valid_reg[rd_idx] && (tag_mem[rd_idx] == pc_reg[31:IDX_W+2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (fill_en) begin
            valid_reg[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= mc_addr_reg[31:IDX_W+2];
            data_mem[fill_idx] <= mc_data;
        end
    end

    logic bht_taken;

`ifdef BHT_EN
    logic [BHT_ENTRIES-1:0] bht_msb;
    logic [BHT_W-1:0]       bht_upd_idx;
    logic                   upd_unused;

    assign bht_upd_idx = bp_upd_pc[BHT_W+1:2];
    assign upd_unused  = ^{bp_upd_pc[31:BHT_W+2], bp_upd_pc[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 2'b01;
                end else if (rdy && bp_upd && (bht_upd_idx == BHT_W'(gi))) begin
                    if (bp_upd_taken) begin
                        if (cnt_reg != 2'b11) cnt_reg <= cnt_reg + 2'd1;
                    end else begin
                        if (cnt_reg != 2'b00) cnt_reg <= cnt_reg - 2'd1;
                    end
                end
            end
            assign bht_msb[gi] = cnt_reg[1];
        end
    endgenerate

    // Combinational read: a same-cycle update lands at the edge, so lookups see the old value.
    assign bht_taken = bht_msb[pc_reg[BHT_W+1:2]];
`else
    logic bht_unused;
    assign bht_unused = ^{bp_upd, bp_upd_pc, bp_upd_taken};
    assign bht_taken  = 1'b0;
`endif

    // Next-PC prediction from the word sitting in the hit line.
    logic [31:0] j_imm, b_imm, pred_pc;
    logic        pred_taken;

    assign j_imm = {{11{hit_word[31]}}, hit_word[31], hit_word[19:12], hit_word[20], hit_word[30:21], 1'b0};
    assign b_imm = {{19{hit_word[31]}}, hit_word[31], hit_word[7], hit_word[30:25], hit_word[11:8], 1'b0};

    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc_reg + 32'd4;
        if (hit_word[6:0] == 7'd111) begin
            pred_taken = 1'b1;
            pred_pc    = pc_reg + j_imm;
        end else if ((hit_word[6:0] == 7'd99) && bht_taken) begin
            pred_taken = 1'b1;
            pred_pc    = pc_reg + b_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            pc_reg       <= '0;
            ins_flag_reg <= 1'b0;
            ins_reg      <= '0;
            jp_flag_reg  <= 1'b0;
            jp_pc_reg    <= '0;
            mc_req_reg   <= 1'b0;
            mc_addr_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ins_flag_reg <= ins_flag_next;
            ins_reg      <= ins_next;
            jp_flag_reg  <= jp_flag_next;
            jp_pc_reg    <= jp_pc_next;
            mc_req_reg   <= mc_req_next;
            mc_addr_reg  <= mc_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ins_flag_next = ins_flag_reg;
        ins_next      = ins_reg;
        jp_flag_next  = jp_flag_reg;
        jp_pc_next    = jp_pc_reg;
        mc_req_next   = mc_req_reg;
        mc_addr_next  = mc_addr_reg;
        fill_en       = 1'b0;

        if (jp_wrong) begin
            ins_flag_next = 1'b0;
            jp_flag_next  = 1'b0;
            pc_next       = jp_target;
            // An outstanding read is always allowed to complete; its data still fills the line.
            if ((state_reg != RUN) && mc_done) begin
                fill_en     = 1'b1;
                mc_req_next = 1'b0;
                state_next  = RUN;
            end else if (state_reg == WAIT) begin
                state_next = ABORT;
            end
        end else if (rdy) begin
            case (state_reg)
                RUN: begin
                    if (!stall_IF) begin
                        if (hit) begin
                            ins_flag_next = 1'b1;
                            ins_next      = hit_word;
                            jp_pc_next    = pc_reg;
                            jp_flag_next  = pred_taken;
                            pc_next       = pred_pc;
                        end else begin
                            ins_flag_next = 1'b0;
                            mc_req_next   = 1'b1;
                            mc_addr_next  = pc_reg;
                            state_next    = WAIT;
                        end
                    end
                end
                WAIT, ABORT: begin
                    if (mc_done) begin
                        fill_en     = 1'b1;
                        mc_req_next = 1'b0;
                        state_next  = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign ins_flag = ins_flag_reg;
    assign ins      = ins_reg;
    assign jp_flag  = jp_flag_reg;
    assign jp_pc    = jp_pc_reg;
    assign mc_req   = mc_req_reg;
    assign mc_addr  = mc_addr_reg;

endmodule
